dat_rx_fifo: RTL and testbench

//  Downstream sink of the camera/SD data arbiter: consumes its REQ/REDAY/DAT_EN/DAT

---
 rtl/dat_rx_pkg.sv | 13 +
 rtl/dat_fifo_ram.sv | 24 ++
 rtl/dat_rx_fifo.sv | 153 +++++++++++++++
 tb/tb_dat_rx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_rx_pkg.sv
// Shared definitions for the arbiter-to-SD-writer receive FIFO.
package dat_rx_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_HOLD = 2'd2
    } rx_state_t;

endpackage

// File: rtl/dat_fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port.
module dat_fifo_ram #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) (
    input  logic                  CLK,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [0:(1<<addr_width)-1];

    // No reset on purpose so the array maps onto distributed/block RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dat_rx_fifo.sv
// Receive FIFO between the data arbiter and the SD writer, with skid/hysteresis
// flow control toward the arbiter and a first-word-fall-through output.
module dat_rx_fifo
    import dat_rx_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int skid       = 4,
    parameter int resume     = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_REQ,
    output logic                  I_REDAY,
    input  logic                  I_DAT_EN,
    input  logic [data_width-1:0] I_DAT,
    output logic                  O_VALID,
    output logic [data_width-1:0] O_DAT,
    input  logic                  O_ACK,
    output logic [addr_width:0]   O_LEVEL,
    output logic                  OVF,
    input  logic                  OVF_CLR
);

    localparam int                DEPTH    = 1 << addr_width;
    localparam logic [addr_width:0] DEPTH_C  = (addr_width+1)'(DEPTH);
    localparam logic [addr_width:0] ONE_C    = (addr_width+1)'(1);
    localparam logic [addr_width:0] SKID_C   = (addr_width+1)'(skid);
    localparam logic [addr_width:0] RESUME_C = (addr_width+1)'(resume);

    rx_state_t             state;
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width-1:0] rd_ptr_next;
    logic [addr_width:0]   count;
    logic [addr_width:0]   count_next;
    logic [addr_width:0]   free_next;
    logic                  wr_ok;
    logic                  pop;
    logic                  bypass;
    logic                  valid_next;
    logic                  valid_r;
    logic                  bypass_r;
    logic [data_width-1:0] bypass_dat;
    logic [data_width-1:0] ram_q;

    // Room is judged on the pre-edge count only; a same-cycle pop does not free a slot.
    // The RAM is addressed with the post-pop read pointer so the next head lands with no bubble,
    // except when that head is the byte being written right now, which is forwarded directly.
    always_comb begin
        wr_ok       = I_DAT_EN && (count != DEPTH_C);
        pop         = O_ACK && valid_r;
        rd_ptr_next = rd_ptr + {{(addr_width-1){1'b0}}, pop};
        count_next  = count;
        if (wr_ok && !pop) begin
            count_next = count + ONE_C;
        end else if (!wr_ok && pop) begin
            count_next = count - ONE_C;
        end
        free_next  = DEPTH_C - count_next;
        bypass     = pop && wr_ok && (count == ONE_C);
        valid_next = (pop ? (count > ONE_C) : (count != '0)) || bypass;
    end

    dat_fifo_ram #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (I_DAT),
        .rd_addr (rd_ptr_next),
        .rd_data (ram_q)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_r    <= 1'b0;
            bypass_r   <= 1'b0;
            bypass_dat <= '0;
            OVF        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + {{(addr_width-1){1'b0}}, 1'b1};
            end
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            valid_r  <= valid_next;
            bypass_r <= bypass;
            if (bypass) begin
                bypass_dat <= I_DAT;
            end
            if (I_DAT_EN && !wr_ok) begin
                OVF <= 1'b1;
            end else if (OVF_CLR) begin
                OVF <= 1'b0;
            end
        end
    end

    // Ready closes below skid free slots and reopens only at resume free slots.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            I_REDAY <= 1'b0;
        end else begin
            I_REDAY <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_REQ) begin
                        if (free_next >= RESUME_C) begin
                            state   <= S_OPEN;
                            I_REDAY <= 1'b1;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_OPEN: begin
                    if (free_next < SKID_C) begin
                        state <= S_HOLD;
                    end else if (!I_REQ) begin
                        state <= S_IDLE;
                    end else begin
                        I_REDAY <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (free_next >= RESUME_C) begin
                        if (I_REQ) begin
                            state   <= S_OPEN;
                            I_REDAY <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign O_VALID = valid_r;
    assign O_DAT   = valid_r ? (bypass_r ? bypass_dat : ram_q) : '0;
    assign O_LEVEL = count;

endmodule

// File: tb/tb_dat_rx_fifo.sv
// Bench for dat_rx_fifo: queue-based reference model compared every cycle, plus directed scenarios.
module tb_dat_rx_fifo;

    localparam int MS_IDLE = 0;
    localparam int MS_OPEN = 1;
    localparam int MS_HOLD = 2;
    localparam int DEPTH   = 16;
    localparam int SKID    = 4;
    localparam int RESUME  = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       I_REQ;
    logic       I_REDAY;
    logic       I_DAT_EN;
    logic [7:0] I_DAT;
    logic       O_VALID;
    logic [7:0] O_DAT;
    logic       O_ACK;
    logic [4:0] O_LEVEL;
    logic       OVF;
    logic       OVF_CLR;

    int checks = 0;
    int errors = 0;

    dat_rx_fifo #(
        .data_width (8),
        .addr_width (4),
        .skid       (SKID),
        .resume     (RESUME)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .I_REQ    (I_REQ),
        .I_REDAY  (I_REDAY),
        .I_DAT_EN (I_DAT_EN),
        .I_DAT    (I_DAT),
        .O_VALID  (O_VALID),
        .O_DAT    (O_DAT),
        .O_ACK    (O_ACK),
        .O_LEVEL  (O_LEVEL),
        .OVF      (OVF),
        .OVF_CLR  (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    // Reference model: stored bytes in a queue; a byte becomes presentable one edge after it
    // was written, unless it becomes head through a pop on the very edge it is written.
    typedef struct packed {
        logic [7:0] d;
        logic       old;
    } ent_t;

    ent_t mq[$];
    int   m_state;
    bit   m_reday;
    bit   m_valid;
    bit   m_ovf;
    bit   m_pop;
    bit   m_acc;
    int   m_free;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mq.delete();
            m_state = MS_IDLE;
            m_reday = 1'b0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_pop = O_ACK && m_valid;
            m_acc = I_DAT_EN && (mq.size() < DEPTH);
            foreach (mq[i]) mq[i].old = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back('{d: I_DAT, old: 1'b0});
            m_valid = (mq.size() > 0) && (mq[0].old || m_pop);
            if (I_DAT_EN && !m_acc) m_ovf = 1'b1;
            else if (OVF_CLR) m_ovf = 1'b0;
            m_free = DEPTH - mq.size();
            case (m_state)
                MS_IDLE: if (I_REQ) m_state = (m_free >= RESUME) ? MS_OPEN : MS_HOLD;
                MS_OPEN: begin
                    if (m_free < SKID) m_state = MS_HOLD;
                    else if (!I_REQ) m_state = MS_IDLE;
                end
                default: if (m_free >= RESUME) m_state = I_REQ ? MS_OPEN : MS_IDLE;
            endcase
            m_reday = (m_state == MS_OPEN);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            checkOutput("model_reday", 32'(I_REDAY), 32'(m_reday));
            checkOutput("model_valid", 32'(O_VALID), 32'(m_valid));
            checkOutput("model_level", 32'(O_LEVEL), 32'(mq.size()));
            checkOutput("model_ovf",   32'(OVF),     32'(m_ovf));
            if (m_valid) checkOutput("model_dat", 32'(O_DAT), 32'(mq[0].d));
        end
    end

    task automatic applyStimulus(input bit req, input bit en, input logic [7:0] dat,
                                 input bit ack, input bit clr);
        I_REQ    = req;
        I_DAT_EN = en;
        I_DAT    = dat;
        O_ACK    = ack;
        OVF_CLR  = clr;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && mq.size() > 0; n++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_empty", 32'(O_LEVEL), 32'd0);
    endtask

    int pushed;
    int popped;
    bit doPush;
    bit doAck;

    initial begin
        RESET = 1'b1;
        I_REQ = 1'b0; I_DAT_EN = 1'b0; I_DAT = 8'h00; O_ACK = 1'b0; OVF_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_valid", 32'(O_VALID), 32'd0);
        checkOutput("rst_reday", 32'(I_REDAY), 32'd0);
        checkOutput("rst_level", 32'(O_LEVEL), 32'd0);
        checkOutput("rst_dat",   32'(O_DAT),   32'd0);
        RESET = 1'b0;

        $display("[TB] basic write/read");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_reday", 32'(I_REDAY), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        checkOutput("t1_latency_valid", 32'(O_VALID), 32'd0);
        checkOutput("t1_level1", 32'(O_LEVEL), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        checkOutput("t1_valid", 32'(O_VALID), 32'd1);
        checkOutput("t1_head_a1", 32'(O_DAT), 32'hA1);
        applyStimulus(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
        checkOutput("t1_level3", 32'(O_LEVEL), 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t1_head_a2", 32'(O_DAT), 32'hA2);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t1_head_a3", 32'(O_DAT), 32'hA3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("t1_empty_valid", 32'(O_VALID), 32'd0);
        checkOutput("t1_empty_level", 32'(O_LEVEL), 32'd0);

        $display("[TB] fill, skid and overflow");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
            if (i == 11) checkOutput("t2_reday_at12", 32'(I_REDAY), 32'd1);
            if (i == 12) checkOutput("t2_reday_at13", 32'(I_REDAY), 32'd0);
        end
        checkOutput("t2_full_level", 32'(O_LEVEL), 32'd16);
        checkOutput("t2_no_ovf", 32'(OVF), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("t2_ovf_set", 32'(OVF), 32'd1);
        checkOutput("t2_level_held", 32'(O_LEVEL), 32'd16);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t2_ovf_clr", 32'(OVF), 32'd0);

        $display("[TB] resume hysteresis");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("t3_head", 32'(O_DAT), 32'(8'(8'hB1 + i)));
            if (i == 6) checkOutput("t3_reday_low", 32'(I_REDAY), 32'd0);
        end
        checkOutput("t3_reday_high", 32'(I_REDAY), 32'd1);
        checkOutput("t3_level8", 32'(O_LEVEL), 32'd8);
        drain();

        $display("[TB] wrap-around streaming");
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
            doPush = (pushed < 40) && (mq.size() < 10) && ($urandom_range(0, 3) != 0);
            doAck  = m_valid && ((mq.size() > 5) || (pushed == 40)) && ($urandom_range(0, 3) != 0);
            if (doAck) begin
                checkOutput("t4_sequence", 32'(O_DAT), 32'(popped));
                popped++;
            end
            applyStimulus(1'b1, doPush, 8'(pushed), doAck, 1'b0);
            if (doPush) pushed++;
        end
        checkOutput("t4_all_popped", 32'(popped), 32'd40);
        checkOutput("t4_no_ovf", 32'(OVF), 32'd0);
        drain();

        $display("[TB] write and pop at level one");
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_head_11", 32'(O_DAT), 32'h11);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("t5_valid_kept", 32'(O_VALID), 32'd1);
        checkOutput("t5_head_55", 32'(O_DAT), 32'h55);
        checkOutput("t5_level1", 32'(O_LEVEL), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_head_55_hold", 32'(O_DAT), 32'h55);
        drain();

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 500; cyc++) begin
            applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end
        drain();

        $display("[TB] asynchronous reset mid-burst");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        checkOutput("t6_level7", 32'(O_LEVEL), 32'd7);
        I_DAT_EN = 1'b1;
        I_DAT    = 8'hEE;
        #2 RESET = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(O_VALID), 32'd0);
        checkOutput("t6_async_reday", 32'(I_REDAY), 32'd0);
        checkOutput("t6_async_level", 32'(O_LEVEL), 32'd0);
        checkOutput("t6_async_dat",   32'(O_DAT),   32'd0);
        checkOutput("t6_async_ovf",   32'(OVF),     32'd0);
        @(negedge CLK);
        I_REQ = 1'b0; I_DAT_EN = 1'b0; O_ACK = 1'b0; OVF_CLR = 1'b0;
        RESET = 1'b0;
        checkOutput("t6_post_valid", 32'(O_VALID), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t6_new_valid", 32'(O_VALID), 32'd1);
        checkOutput("t6_new_head", 32'(O_DAT), 32'h3C);
        checkOutput("t6_new_level", 32'(O_LEVEL), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
